regfile_dump: RTL and testbench

- Read-side engine for the 32x32 register file. It sweeps a contiguous address range through both read ports (src_add1/src_add2) and streams the words out on a valid/ready interface.
- Counterpart to the write-sweep path that fills the file. Used for register dump, debug readout and self-check after a fill.
- Sits between the register file's combinational read ports and a downstream consumer, such as a UART or a checker.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_dump_buf.sv | 32 +++
 rtl/regfile_dump.sv | 178 +++++++++++++++++
 tb/tb_regfile_dump.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the register-file dump engine.
package regfile_pkg;

  localparam int unsigned REGF_DATA_W = 32;
  localparam int unsigned REGF_ADDR_W = 5;
  localparam int unsigned REGF_DEPTH  = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SENDA,
    SENDB,
    CSUM,
    FIN
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_buf.sv
// Two-word capture buffer: both read ports are latched on the fetch edge and
// held until the next fetch, so backpressure never disturbs the presented word.
module regfile_dump_buf #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_capture,
  input  logic              i_sel_b,
  input  logic [DATA_W-1:0] i_data_a,
  input  logic [DATA_W-1:0] i_data_b,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] r_buf_a;
  logic [DATA_W-1:0] r_buf_b;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_buf_a <= '0;
      r_buf_b <= '0;
    end else if (i_capture) begin
      r_buf_a <= i_data_a;
      r_buf_b <= i_data_b;
    end
  end

  always_comb begin
    o_data = i_sel_b ? r_buf_b : r_buf_a;
  end

endmodule

// File: rtl/regfile_dump.sv
// Sweeps a wrapping address range through both register-file read ports and streams
// the words on a valid/ready interface. REGDUMP_CSUM_EN appends an XOR checksum beat.
module regfile_dump
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REGF_DATA_W,
  parameter int unsigned ADDR_W = REGF_ADDR_W,
  parameter int unsigned DEPTH  = REGF_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_first_addr,
  input  logic [ADDR_W:0]   i_num_words,
  output logic [ADDR_W-1:0] o_src_add1,
  output logic [ADDR_W-1:0] o_src_add2,
  input  logic [DATA_W-1:0] i_rd_data1,
  input  logic [DATA_W-1:0] i_rd_data2,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_last,
  output logic              o_busy,
  output logic              o_done
);

`ifdef REGDUMP_CSUM_EN
  localparam dump_state_t END_ST = CSUM;
`else
  localparam dump_state_t END_ST = FIN;
`endif

  dump_state_t       r_state;
  dump_state_t       w_state_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_rem;
  logic [ADDR_W-1:0] r_src_add1;
  logic [ADDR_W-1:0] r_src_add2;
  logic [ADDR_W:0]   w_count;
  logic [DATA_W-1:0] w_buf_data;
  logic              w_hs;
  logic              w_rem_last;
`ifdef REGDUMP_CSUM_EN
  logic [DATA_W-1:0] r_csum;
`endif

  assign w_count    = (i_num_words > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : i_num_words;
  assign w_hs       = o_out_valid & i_out_ready;
  assign w_rem_last = (r_rem == (ADDR_W+1)'(1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_next = (w_count == '0) ? END_ST : FETCH;
        end
      end
      FETCH: w_state_next = SENDA;
      SENDA: begin
        if (w_hs) begin
          w_state_next = w_rem_last ? END_ST : SENDB;
        end
      end
      SENDB: begin
        if (w_hs) begin
          w_state_next = w_rem_last ? END_ST : FETCH;
        end
      end
      CSUM: begin
        if (w_hs) begin
          w_state_next = FIN;
        end
      end
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Read addresses are registered so they hold their last fetch value between fetches.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr      <= '0;
      r_rem      <= '0;
      r_src_add1 <= '0;
      r_src_add2 <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_ptr <= i_first_addr;
            r_rem <= w_count;
            if (w_count != '0) begin
              r_src_add1 <= i_first_addr;
              r_src_add2 <= i_first_addr + ADDR_W'(1);
            end
          end
        end
        FETCH: r_ptr <= r_ptr + ADDR_W'(2);
        SENDA: begin
          if (w_hs) begin
            r_rem <= r_rem - (ADDR_W+1)'(1);
          end
        end
        SENDB: begin
          if (w_hs) begin
            r_rem <= r_rem - (ADDR_W+1)'(1);
            if (!w_rem_last) begin
              r_src_add1 <= r_ptr;
              r_src_add2 <= r_ptr + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef REGDUMP_CSUM_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_csum <= '0;
    end else if (r_state == IDLE && i_start) begin
      r_csum <= '0;
    end else if ((r_state == SENDA || r_state == SENDB) && w_hs) begin
      r_csum <= r_csum ^ w_buf_data;
    end
  end
`endif

  regfile_dump_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_capture (r_state == FETCH),
    .i_sel_b   (r_state == SENDB),
    .i_data_a  (i_rd_data1),
    .i_data_b  (i_rd_data2),
    .o_data    (w_buf_data)
  );

  always_comb begin
    o_src_add1  = r_src_add1;
    o_src_add2  = r_src_add2;
    o_out_data  = '0;
    o_out_valid = 1'b0;
    o_out_last  = 1'b0;
    o_busy      = (r_state != IDLE) && (r_state != FIN);
    o_done      = (r_state == FIN);
    unique case (r_state)
      SENDA, SENDB: begin
        o_out_data  = w_buf_data;
        o_out_valid = 1'b1;
`ifndef REGDUMP_CSUM_EN
        o_out_last  = w_rem_last;
`endif
      end
      CSUM: begin
`ifdef REGDUMP_CSUM_EN
        o_out_data  = r_csum;
        o_out_last  = 1'b1;
`endif
        o_out_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: a behavioural register file drives the read
// ports, sweeps are predicted from address arithmetic and checked by a stream monitor.
module tb_regfile_dump;
  import regfile_pkg::*;

  localparam int D = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  first_addr = '0;
  logic [5:0]  num_words = '0;
  logic [4:0]  src_add1, src_add2;
  logic [31:0] rd_data1, rd_data2, out_data;
  logic        out_valid, out_last, busy, done;
  logic        out_ready = 1'b1;

  logic [31:0] mem [D];

  assign rd_data1 = mem[src_add1];
  assign rd_data2 = mem[src_add2];

  always #5 clk = ~clk;

  regfile_dump dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_first_addr (first_addr),
    .i_num_words  (num_words),
    .o_src_add1   (src_add1),
    .o_src_add2   (src_add2),
    .i_rd_data1   (rd_data1),
    .i_rd_data2   (rd_data2),
    .o_out_data   (out_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_last   (out_last),
    .o_busy       (busy),
    .o_done       (done)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int hs_cnt = 0;
  int last_hs_cyc = -1;
  int first_vld_cyc = -1;
  int ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stream monitor: pops the scoreboard on every handshake and polices stalls.
  initial begin
    beat_t       b;
    logic        held = 1'b0;
    logic [31:0] held_data = '0;
    logic        held_last = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_valid", {31'b0, out_valid}, 32'd1);
          check("stall_data", out_data, held_data);
          check("stall_last", {31'b0, out_last}, {31'b0, held_last});
        end
        if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (out_valid && out_ready) begin
          hs_cnt++;
          last_hs_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_beat: got 0x%08h expected no beat (cycle %0d)", out_data, cyc);
          end else begin
            b = exp_q.pop_front();
            check("beat_data", out_data, b.data);
            check("beat_last", {31'b0, out_last}, {31'b0, b.last});
          end
          held = 1'b0;
        end else if (out_valid) begin
          held      = 1'b1;
          held_data = out_data;
          held_last = out_last;
        end else begin
          held = 1'b0;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
          ph++;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_sweep(input int f, input int n, input bit poke);
    int          cnt, dc0, sc, exp_first;
    bit          beats;
    logic [31:0] x;
    logic [4:0]  fa;
    cnt = (n > D) ? D : n;
    x = '0;
    for (int i = 0; i < cnt; i++) begin
      beat_t b;
      b.data = mem[(f + i) % D];
      b.last = (i == cnt - 1);
`ifdef REGDUMP_CSUM_EN
      b.last = 1'b0;
`endif
      x ^= b.data;
      exp_q.push_back(b);
    end
    beats = (cnt > 0);
`ifdef REGDUMP_CSUM_EN
    begin
      beat_t c;
      c.data = x;
      c.last = 1'b1;
      exp_q.push_back(c);
      beats = 1'b1;
    end
`endif
    exp_first = (cnt > 0) ? 2 : 1;
    fa = 5'(f);
    dc0 = done_cnt;
    first_vld_cyc = -1;
    @(posedge clk);
    #1;
    start      = 1'b1;
    first_addr = fa;
    num_words  = 6'(n);
    @(posedge clk);
    sc = cyc;
    #1;
    start      = 1'b0;
    first_addr = 5'($urandom);
    num_words  = 6'($urandom);
    @(negedge clk);
    #1;
    check("busy_after_start", {31'b0, busy}, {31'b0, beats});
    if (cnt > 0) begin
      check("fetch_add1", {27'b0, src_add1}, {27'b0, fa});
      check("fetch_add2", {27'b0, src_add2}, {27'b0, 5'(fa + 5'd1)});
    end
    if (poke && cnt >= 2) begin
      start      = 1'b1;
      first_addr = 5'($urandom);
      num_words  = 6'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    for (int t = 0; t < 2000 && done_cnt == dc0; t++) @(negedge clk);
    #1;
    if (done_cnt == dc0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 2000 cycles");
    end else begin
      check("queue_drained", exp_q.size(), 0);
      check("busy_at_done", {31'b0, busy}, 32'd0);
      if (beats) begin
        check("first_valid_lat", first_vld_cyc, sc + exp_first);
        check("done_after_last", done_cyc, last_hs_cyc + 1);
      end else begin
        check("zero_done_lat", done_cyc, sc + 1);
        check("zero_no_valid", first_vld_cyc, -1);
      end
    end
    exp_q.delete();
    @(negedge clk);
    #1;
    check("idle_done", {31'b0, done}, 32'd0);
    check("idle_valid", {31'b0, out_valid}, 32'd0);
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("single_done", done_cnt, dc0 + 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_src1"}, {27'b0, src_add1}, 32'd0);
    check({tag, "_src2"}, {27'b0, src_add2}, 32'd0);
    check({tag, "_data"}, out_data, 32'd0);
    check({tag, "_ctl"}, {28'b0, out_valid, out_last, busy, done}, 32'd0);
  endtask

  task automatic reset_mid_sweep();
    int hs0, dc0;
    for (int i = 0; i < D; i++) mem[i] = $urandom;
    ready_mode = 0;
    for (int i = 0; i < D; i++) begin
      beat_t b;
      b.data = mem[i];
      b.last = (i == D - 1);
`ifdef REGDUMP_CSUM_EN
      b.last = 1'b0;
`endif
      exp_q.push_back(b);
    end
    hs0 = hs_cnt;
    dc0 = done_cnt;
    @(posedge clk);
    #1;
    start      = 1'b1;
    first_addr = '0;
    num_words  = 6'd32;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int t = 0; t < 50 && hs_cnt < hs0 + 3; t++) begin
      @(negedge clk);
      #1;
    end
    check("reset_setup_beats", hs_cnt, hs0 + 3);
    // Next cycle is SENDB; reset is sampled at the edge ending it.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    exp_q.delete();
    check_all_zero("abort");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt, dc0);
    check("abort_idle_valid", {31'b0, out_valid}, 32'd0);
    run_sweep(0, 32, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < D; i++) mem[i] = 32'(i) * 32'h1111_1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    ready_mode = 0;
    run_sweep(0, 32, 1'b0);
    run_sweep(30, 5, 1'b0);
    ready_mode = 1;
    run_sweep(4, 3, 1'b0);
    ready_mode = 0;
    run_sweep(7, 0, 1'b0);
    run_sweep(31, 3, 1'b1);
    ready_mode = 2;
    run_sweep(10, 40, 1'b1);
    run_sweep(3, 63, 1'b0);

    mem[0] = 32'h1;
    mem[1] = 32'h2;
    mem[2] = 32'h4;
    mem[3] = 32'h8;
    ready_mode = 0;
    run_sweep(0, 4, 1'b0);

    reset_mid_sweep();

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < D; i++) mem[i] = $urandom;
      ready_mode = int'($urandom_range(0, 2));
      run_sweep(int'($urandom_range(0, 31)), int'($urandom_range(0, 40)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
